// File: rtl/ibus_pkg.sv
// Shared constants for the instruction-bus slot allocator.
// Also holds the modular index helper used by the free-slot picker.
package ibus_pkg;

  localparam int IBUS_ALLOC_FIXED = 0;
  localparam int IBUS_ALLOC_RR    = 1;

  localparam int IBUS_DEF_SLOTS = 4;
  localparam int IBUS_DEF_TAG_W = 8;

  // (a + b) mod n for a, b < n, without a divider.
  function automatic int ibus_mod_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/ibus_free_pick.sv
// Combinational first-free-slot picker: rotate by start, priority-pick the
// first clear bit, rotate the winner back. start = 0 gives fixed priority.
module ibus_free_pick
  import ibus_pkg::*;
#(
  parameter int N     = IBUS_DEF_SLOTS,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index,
  output logic             any_free
);

  int          start_i;
  int          pos;
  int          abs_idx;
  logic        found;
  logic [N-1:0] free_rot;

  always_comb begin
    start_i  = (int'(start) < N) ? int'(start) : 0;
    free_rot = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ibus_mod_add(start_i, i, N) == j) free_rot[i] = ~valid[j];
      end
    end

    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      if (free_rot[i] && !found) begin
        found = 1'b1;
        pos   = i;
      end
    end

    abs_idx  = ibus_mod_add(start_i, pos, N);
    any_free = found;
    index    = found ? IDX_W'(abs_idx) : '0;
    grant    = '0;
    for (int j = 0; j < N; j++) begin
      grant[j] = found && (abs_idx == j);
    end
  end

endmodule

// File: rtl/ibus_slot_alloc.sv
// Outstanding-fetch slot tracker: grants free slots, stores a tag per slot,
// and returns the tag when the response releases the slot.
module ibus_slot_alloc
  import ibus_pkg::*;
#(
  parameter int N       = IBUS_DEF_SLOTS,
  parameter int TAG_W   = IBUS_DEF_TAG_W,
  parameter int RR_MODE = IBUS_ALLOC_FIXED,
  parameter int IDX_W   = $clog2(N),
  parameter int CNT_W   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic [IDX_W-1:0] alloc_slot,
  output logic [N-1:0]     alloc_onehot,
  input  logic             rel_valid,
  input  logic [IDX_W-1:0] rel_slot,
  output logic [TAG_W-1:0] rel_tag,
  output logic             rel_err,
  output logic [N-1:0]     slot_valid,
  output logic [CNT_W-1:0] occ_cnt,
  output logic             empty,
  output logic             full
);

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [CNT_W-1:0] occ_q;
  logic [IDX_W-1:0] rr_q;
  logic             rel_err_q;

  logic [IDX_W-1:0] pick_start;
  logic [N-1:0]     pick_grant;
  logic [IDX_W-1:0] pick_index;
  logic             pick_any;

  logic             rel_bit;
  logic             rel_hit;
  logic             rel_do;
  logic             rel_bad;
  logic             alloc_fire;
  logic [IDX_W-1:0] rr_next;

  assign pick_start = (RR_MODE == IBUS_ALLOC_RR) ? rr_q : '0;

  ibus_free_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid    (valid_q),
    .start    (pick_start),
    .grant    (pick_grant),
    .index    (pick_index),
    .any_free (pick_any)
  );

  // Alloc handshake: a transfer happens on a cycle where alloc_valid && alloc_ready.
  // alloc_ready depends only on registered occupancy and flush, never on alloc_valid,
  // and alloc_slot/alloc_onehot are meaningful whenever alloc_ready is high.
  assign alloc_ready  = pick_any && !flush;
  assign alloc_slot   = pick_index;
  assign alloc_onehot = pick_any ? pick_grant : '0;
  assign alloc_fire   = alloc_valid && alloc_ready;

  // Decoded reads so an out-of-range rel_slot reads as "not valid", tag 0.
  always_comb begin
    rel_bit = 1'b0;
    rel_tag = '0;
    for (int i = 0; i < N; i++) begin
      if (rel_slot == IDX_W'(i)) begin
        rel_bit = valid_q[i];
        rel_tag = tag_q[i];
      end
    end
  end

  assign rel_hit = rel_valid && rel_bit;
  assign rel_do  = rel_hit && !flush;
  assign rel_bad = rel_valid && !rel_bit && !flush;
  assign rr_next = (alloc_slot == IDX_W'(N - 1)) ? '0 : alloc_slot + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      occ_q     <= '0;
      rr_q      <= '0;
      rel_err_q <= 1'b0;
      for (int i = 0; i < N; i++) tag_q[i] <= '0;
    end else if (flush) begin
      // Tags are deliberately kept; only occupancy state is dropped.
      valid_q   <= '0;
      occ_q     <= '0;
      rr_q      <= '0;
      rel_err_q <= 1'b0;
    end else begin
      rel_err_q <= rel_bad;
      for (int i = 0; i < N; i++) begin
        if (alloc_fire && pick_grant[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= alloc_tag;
        end else if (rel_do && rel_slot == IDX_W'(i)) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (alloc_fire && !rel_do)      occ_q <= occ_q + CNT_W'(1);
      else if (!alloc_fire && rel_do) occ_q <= occ_q - CNT_W'(1);
      if (alloc_fire && RR_MODE == IBUS_ALLOC_RR) rr_q <= rr_next;
    end
  end

  assign slot_valid = valid_q;
  assign occ_cnt    = occ_q;
  assign rel_err    = rel_err_q;
  assign empty      = (occ_q == '0);
  assign full       = (occ_q == CNT_W'(N));

  occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
    occ_q == CNT_W'($countones(valid_q)));

endmodule

// File: tb/tb_ibus_slot_alloc.sv
// Bench for ibus_slot_alloc: one fixed-priority and one round-robin instance
// driven from directed vector tables, plus an asynchronous reset sequence.
module tb_ibus_slot_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_flush, a_av, a_rv, a_ready, a_err, a_empty, a_full;
  logic [7:0] a_tag, a_rtag;
  logic [1:0] a_rs, a_slot;
  logic [3:0] a_oh, a_sv;
  logic [2:0] a_occ;

  logic       b_flush, b_av, b_rv, b_ready, b_err, b_empty, b_full;
  logic [7:0] b_tag, b_rtag;
  logic [1:0] b_rs, b_slot;
  logic [3:0] b_oh, b_sv;
  logic [2:0] b_occ;

  ibus_slot_alloc #(.N(4), .TAG_W(8), .RR_MODE(0)) dut_fixed (
    .clk(clk), .rst(rst), .flush(a_flush),
    .alloc_valid(a_av), .alloc_ready(a_ready), .alloc_tag(a_tag),
    .alloc_slot(a_slot), .alloc_onehot(a_oh),
    .rel_valid(a_rv), .rel_slot(a_rs), .rel_tag(a_rtag), .rel_err(a_err),
    .slot_valid(a_sv), .occ_cnt(a_occ), .empty(a_empty), .full(a_full)
  );

  ibus_slot_alloc #(.N(4), .TAG_W(8), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .flush(b_flush),
    .alloc_valid(b_av), .alloc_ready(b_ready), .alloc_tag(b_tag),
    .alloc_slot(b_slot), .alloc_onehot(b_oh),
    .rel_valid(b_rv), .rel_slot(b_rs), .rel_tag(b_rtag), .rel_err(b_err),
    .slot_valid(b_sv), .occ_cnt(b_occ), .empty(b_empty), .full(b_full)
  );

  typedef struct {
    logic       fl;
    logic       av;
    logic [7:0] tag;
    logic       rv;
    logic [1:0] rs;
    logic       e_ready;
    logic [1:0] e_slot;
    logic [3:0] e_oh;
    logic [7:0] e_rtag;
    logic [3:0] e_sv;
    logic [2:0] e_occ;
    logic       e_err;
    logic       e_full;
    logic       e_empty;
  } vec_t;

  vec_t tbl_a[16];
  vec_t tbl_b[12];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int fl, input int av, input int tag, input int rv,
                              input int rs, input int rdy, input int slot, input int oh,
                              input int rtag, input int sv, input int occ, input int err,
                              input int fu, input int em);
    vec_t v;
    v.fl = 1'(fl);        v.av = 1'(av);         v.tag = 8'(tag);
    v.rv = 1'(rv);        v.rs = 2'(rs);         v.e_ready = 1'(rdy);
    v.e_slot = 2'(slot);  v.e_oh = 4'(oh);       v.e_rtag = 8'(rtag);
    v.e_sv = 4'(sv);      v.e_occ = 3'(occ);     v.e_err = 1'(err);
    v.e_full = 1'(fu);    v.e_empty = 1'(em);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0h required %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input vec_t v);
    if (!sel) begin
      a_flush = v.fl; a_av = v.av; a_tag = v.tag; a_rv = v.rv; a_rs = v.rs;
    end else begin
      b_flush = v.fl; b_av = v.av; b_tag = v.tag; b_rv = v.rv; b_rs = v.rs;
    end
  endtask

  // Drive at negedge, check combinational outputs mid-cycle, then registered ones after the edge.
  task automatic apply(input bit sel, input int idx, input vec_t v);
    string p;
    p = sel ? "rr" : "fixed";
    @(negedge clk);
    drive(sel, v);
    #2;
    chk({p, ".alloc_ready"}, idx, sel ? b_ready : a_ready, v.e_ready);
    chk({p, ".alloc_onehot"}, idx, sel ? b_oh : a_oh, v.e_oh);
    if (v.e_ready) chk({p, ".alloc_slot"}, idx, sel ? b_slot : a_slot, v.e_slot);
    if (v.rv) chk({p, ".rel_tag"}, idx, sel ? b_rtag : a_rtag, v.e_rtag);
    @(posedge clk);
    #1;
    chk({p, ".slot_valid"}, idx, sel ? b_sv : a_sv, v.e_sv);
    chk({p, ".occ_cnt"}, idx, sel ? b_occ : a_occ, v.e_occ);
    chk({p, ".rel_err"}, idx, sel ? b_err : a_err, v.e_err);
    chk({p, ".full"}, idx, sel ? b_full : a_full, v.e_full);
    chk({p, ".empty"}, idx, sel ? b_empty : a_empty, v.e_empty);
  endtask

  initial begin
    //             fl av tag   rv rs  rdy slot oh       rtag   sv       occ err full empty
    tbl_a[0]  = mk(0, 1, 'h11, 0, 0,  1,  0,   4'b0001, 0,     4'b0001, 1,  0,  0,   0);
    tbl_a[1]  = mk(0, 1, 'h12, 0, 0,  1,  1,   4'b0010, 0,     4'b0011, 2,  0,  0,   0);
    tbl_a[2]  = mk(0, 1, 'h13, 0, 0,  1,  2,   4'b0100, 0,     4'b0111, 3,  0,  0,   0);
    tbl_a[3]  = mk(0, 1, 'h14, 0, 0,  1,  3,   4'b1000, 0,     4'b1111, 4,  0,  1,   0);
    tbl_a[4]  = mk(0, 1, 'h55, 0, 0,  0,  0,   4'b0000, 0,     4'b1111, 4,  0,  1,   0);
    tbl_a[5]  = mk(0, 0, 0,    1, 2,  0,  0,   4'b0000, 'h13,  4'b1011, 3,  0,  0,   0);
    tbl_a[6]  = mk(0, 1, 'h22, 0, 0,  1,  2,   4'b0100, 0,     4'b1111, 4,  0,  1,   0);
    tbl_a[7]  = mk(0, 0, 0,    1, 3,  0,  0,   4'b0000, 'h14,  4'b0111, 3,  0,  0,   0);
    tbl_a[8]  = mk(0, 1, 'hAA, 1, 0,  1,  3,   4'b1000, 'h11,  4'b1110, 3,  0,  0,   0);
    tbl_a[9]  = mk(0, 0, 0,    1, 1,  1,  0,   4'b0001, 'h12,  4'b1100, 2,  0,  0,   0);
    tbl_a[10] = mk(0, 0, 0,    1, 1,  1,  0,   4'b0001, 'h12,  4'b1100, 2,  1,  0,   0);
    tbl_a[11] = mk(0, 0, 0,    0, 0,  1,  0,   4'b0001, 0,     4'b1100, 2,  0,  0,   0);
    tbl_a[12] = mk(0, 1, 'h33, 0, 0,  1,  0,   4'b0001, 0,     4'b1101, 3,  0,  0,   0);
    tbl_a[13] = mk(1, 1, 'h44, 1, 0,  0,  0,   4'b0010, 'h33,  4'b0000, 0,  0,  0,   1);
    tbl_a[14] = mk(1, 0, 0,    1, 3,  0,  0,   4'b0001, 'hAA,  4'b0000, 0,  0,  0,   1);
    tbl_a[15] = mk(0, 1, 'h77, 0, 0,  1,  0,   4'b0001, 0,     4'b0001, 1,  0,  0,   0);

    tbl_b[0]  = mk(0, 1, 'h01, 0, 0,  1,  0,   4'b0001, 0,     4'b0001, 1,  0,  0,   0);
    tbl_b[1]  = mk(0, 0, 0,    1, 0,  1,  1,   4'b0010, 'h01,  4'b0000, 0,  0,  0,   1);
    tbl_b[2]  = mk(0, 1, 'h02, 0, 0,  1,  1,   4'b0010, 0,     4'b0010, 1,  0,  0,   0);
    tbl_b[3]  = mk(0, 1, 'h03, 0, 0,  1,  2,   4'b0100, 0,     4'b0110, 2,  0,  0,   0);
    tbl_b[4]  = mk(0, 1, 'h04, 0, 0,  1,  3,   4'b1000, 0,     4'b1110, 3,  0,  0,   0);
    tbl_b[5]  = mk(0, 0, 0,    1, 1,  1,  0,   4'b0001, 'h02,  4'b1100, 2,  0,  0,   0);
    tbl_b[6]  = mk(0, 0, 0,    1, 2,  1,  0,   4'b0001, 'h03,  4'b1000, 1,  0,  0,   0);
    tbl_b[7]  = mk(0, 1, 'h05, 0, 0,  1,  0,   4'b0001, 0,     4'b1001, 2,  0,  0,   0);
    tbl_b[8]  = mk(0, 1, 'h06, 0, 0,  1,  1,   4'b0010, 0,     4'b1011, 3,  0,  0,   0);
    tbl_b[9]  = mk(0, 1, 'h07, 0, 0,  1,  2,   4'b0100, 0,     4'b1111, 4,  0,  1,   0);
    tbl_b[10] = mk(0, 0, 0,    1, 0,  0,  0,   4'b0000, 'h05,  4'b1110, 3,  0,  0,   0);
    tbl_b[11] = mk(0, 1, 'h08, 0, 0,  1,  0,   4'b0001, 0,     4'b1111, 4,  0,  1,   0);

    a_flush = 0; a_av = 0; a_tag = 0; a_rv = 0; a_rs = 0;
    b_flush = 0; b_av = 0; b_tag = 0; b_rv = 0; b_rs = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset.slot_valid", 0, a_sv, 4'b0000);
    chk("reset.occ_cnt", 0, a_occ, 3'd0);
    chk("reset.empty", 0, a_empty, 1'b1);
    chk("reset.full", 0, a_full, 1'b0);
    chk("reset.alloc_ready", 0, a_ready, 1'b1);
    chk("reset.rel_err", 0, a_err, 1'b0);
    chk("reset.rr_occ_cnt", 0, b_occ, 3'd0);

    for (int i = 0; i < 16; i++) apply(1'b0, i, tbl_a[i]);
    @(negedge clk);
    a_av = 0; a_rv = 0; a_flush = 0;
    for (int i = 0; i < 12; i++) apply(1'b1, i, tbl_b[i]);
    @(negedge clk);
    b_av = 0; b_rv = 0; b_flush = 0;

    // Asynchronous reset between edges: state must clear before the next clock.
    @(negedge clk);
    a_rs = 2'd0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.slot_valid", 0, a_sv, 4'b0000);
    chk("async_rst.occ_cnt", 0, a_occ, 3'd0);
    chk("async_rst.empty", 0, a_empty, 1'b1);
    chk("async_rst.tag_cleared", 0, a_rtag, 8'h00);
    chk("async_rst.rr_occ_cnt", 0, b_occ, 3'd0);
    chk("async_rst.rr_full", 0, b_full, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst.alloc_ready", 0, a_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
